bcd_converter: RTL
==================

# bcd_converter

Sequential binary-to-BCD converter with a one-hot digit decoder. It generalises the existing 4-bit one-hot BCD decode to a parametrised input width and digit count. It runs an iterative shift-add-3 (double-dabble) conversion under a start/done handshake and saturates on out-of-range values. The decoded digits drive the display and indicator logic downstream.

## Interface
Parameters:
- BIN_W, 14: binary input width. Legal range 4..32.
- DIGITS, 4: number of BCD output digits. Legal range 1..8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request conversion of bin_in. Sampled only when busy=0.
- bin_in  in  BIN_W  unsigned binary value. Captured on the accepted start cycle.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; bcd_out and overflow are valid from this cycle.
- bcd_out  out  4*DIGITS  packed BCD result; digit 0 occupies bits [3:0]. Held until the next done.
- overflow  out  1  last captured bin_in exceeded 10^DIGITS−1. Held until the next done.
- dec_sel  in  3  digit index to decode. Values ≥ DIGITS select nothing.
- dec_onehot  out  10  one-hot of bcd_out digit dec_sel: bit k set when the digit equals k. All zero if dec_sel is out of range.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures bin_in into the shift register and clears the BCD accumulator.
  - The captured value is compared against MAX_VAL = 10^DIGITS−1, and the result is latched into an internal ovf flag.
  - Transition to SHIFT; iteration counter is set to BIN_W−1.
- SHIFT, each cycle:
  - Every accumulator digit ≥ 5 first gets +3.
  - Then {accumulator, shift register} shifts left by 1.
  - When the counter reaches 0, go to DONE; otherwise decrement the counter.
- DONE, single cycle:
  - Load bcd_out from the accumulator, or all digits = 9 if ovf is set.
  - overflow ← ovf; done=1.
  - Return to IDLE.
- Accumulator width is 4*DIGITS. Bits shifted beyond the top digit are discarded. This is harmless because saturation covers every case where the value does not fit.
- start while busy=1 is ignored, with no queuing and no effect on the conversion in flight.
- start asserted in the DONE cycle is ignored. It is accepted in the following IDLE cycle if still held.
- dec_onehot is combinational from registered bcd_out and dec_sel, with no added latency. A digit value of 10..15 cannot occur and decodes to all zero.
- Reset (rst_n=0 at an edge), applied mid-conversion, aborts immediately:
  - State → IDLE.
  - bcd_out=0, overflow=0, busy=0, done=0.
  - Counter, shift register and accumulator are cleared.
  - dec_onehot then equals 10'b0000000001 for any in-range dec_sel.

## Timing
- Accepted start at edge T:
  - busy=1 from T+1 through the last DONE cycle.
  - SHIFT occupies cycles T+1 .. T+BIN_W.
  - DONE and done=1 in cycle T+BIN_W+1.
- Latency from start acceptance to done is BIN_W+1 cycles.
- Minimum start-to-start spacing is BIN_W+2 cycles.
- busy deasserts the cycle after done.
- bcd_out and overflow change only in the DONE cycle or on reset.

## Structure
- Package bcd_pkg holds:
  - the digit-width constant 4;
  - FSM state encoding (IDLE/SHIFT/DONE);
  - a constant function pow10(DIGITS) returning MAX_VAL+1, sized to 32 bits;
  - the 4-bit "digit all 9s" constant.
- Sub-module bcd_digit_dec: 4-bit BCD in, 10-bit one-hot out, purely combinational. The top level instantiates it once, fed by a dec_sel mux.
- Counter width is clog2(BIN_W). The overflow comparison is done at the BIN_W-bit vs 32-bit constant width, with no truncation.

## Test plan
Defaults BIN_W=14, DIGITS=4 unless stated.
- Reset, then idle with dec_sel=0 → bcd_out=0x0000, overflow=0, busy=0, done=0, dec_onehot=10'h001.
- start with bin_in=9999 → done exactly 15 cycles after acceptance; bcd_out=0x9999, overflow=0. With dec_sel=2, dec_onehot=10'h200.
- bin_in=10000, then bin_in=16383 → bcd_out=0x9999, overflow=1 both times. A following conversion of bin_in=1234 → bcd_out=0x1234, overflow=0.
- start held high through a conversion of 0, with bin_in changed to 42 during busy → first result 0x0000. A second conversion is accepted on the cycle after busy drops and returns 0x0042. Consecutive done pulses are 16 cycles apart.
- rst_n low for one cycle at SHIFT cycle 7 → no done pulse, outputs at reset values. A fresh start with bin_in=507 → 0x0507 after 15 cycles.
- Parameter sweep BIN_W=8, DIGITS=3, all 256 inputs vs a reference model: values ≤255 convert exactly, overflow is never set, and dec_sel=3..7 gives dec_onehot=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and helpers for the binary-to-BCD
// converter and its one-hot digit decoder.
package bcd_pkg;

  localparam int DIG_W = 4;                  // bits per BCD digit
  localparam logic [DIG_W-1:0] DIGIT_NINE = 4'h9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // 10**n at 32 bits; with n <= 8 this never wraps.
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: 4-bit BCD digit to 10-bit one-hot, purely combinational.
//   bcd    in  4   BCD digit
//   onehot out 10  bit k set when bcd == k; all zero for codes 10..15
module bcd_digit_dec (
  input  logic [3:0] bcd,
  output logic [9:0] onehot
);

  assign onehot = (bcd <= 4'd9) ? (10'd1 << bcd) : 10'd0;

endmodule

// File: rtl/bcd_converter.sv
// bcd_converter: iterative double-dabble binary-to-BCD converter with a
// start/done handshake, saturation to all-9s on out-of-range input, and a
// one-hot decode of a selectable result digit.
//   clk, rst_n  clock, synchronous active-low reset
//   start       request conversion (only sampled while idle)
//   bin_in      unsigned value, captured on the accepted start
//   busy        conversion in progress (SHIFT and DONE)
//   done        one-cycle pulse, bcd_out/overflow valid from this cycle
//   bcd_out     packed BCD result, digit 0 in [3:0], held until next done
//   overflow    last captured value exceeded 10^DIGITS-1
//   dec_sel     digit index to decode; >= DIGITS selects nothing
//   dec_onehot  one-hot of the selected bcd_out digit
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [DIG_W*DIGITS-1:0] bcd_out,
  output logic                    overflow,
  input  logic [2:0]              dec_sel,
  output logic [9:0]              dec_onehot
);

  localparam int          ACC_W   = DIG_W * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W);
  localparam logic [31:0] MAX_VAL = pow10(DIGITS) - 32'd1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               overflow_q, overflow_d;

  logic [ACC_W-1:0]   acc_adj, acc_shift;

  // Add-3 correction on every digit >= 5, then shift in the next binary bit.
  // Bits leaving the top digit are dropped; saturation covers those values.
  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[i*DIG_W +: DIG_W] >= 4'd5)
        acc_adj[i*DIG_W +: DIG_W] = acc_q[i*DIG_W +: DIG_W] + 4'd3;
      else
        acc_adj[i*DIG_W +: DIG_W] = acc_q[i*DIG_W +: DIG_W];
    end
    acc_shift = (acc_adj << 1) | ACC_W'(sr_q[BIN_W-1]);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = bin_in;
          acc_d   = '0;
          // Widen both sides so a 32-bit input is compared without truncation.
          ovf_d   = 64'(bin_in) > 64'(MAX_VAL);
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_shift;
        sr_d  = sr_q << 1;
        if (cnt_q == '0) begin
          // Result registers load on the edge entering DONE so they are
          // already valid while done is high.
          state_d    = S_DONE;
          bcd_d      = ovf_q ? {DIGITS{DIGIT_NINE}} : acc_shift;
          overflow_d = ovf_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      acc_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;

  // Digit select for the single shared decoder.
  logic [DIG_W-1:0] sel_digit;
  logic             sel_ok;
  logic [9:0]       dec_raw;

  always_comb begin
    sel_digit = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_sel == 3'(i)) begin
        sel_digit = bcd_q[i*DIG_W +: DIG_W];
        sel_ok    = 1'b1;
      end
    end
  end

  bcd_digit_dec u_dec (
    .bcd    (sel_digit),
    .onehot (dec_raw)
  );

  assign dec_onehot = sel_ok ? dec_raw : 10'd0;

endmodule
